vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter AW, default 14, word-address width (word address bits [AW:1]).
REQ-002 Parameter DW, default 16, data width.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 vid_req  input  1  one-cycle video fetch strobe.
REQ-006 vid_addr  input  AW  video word address, sampled with vid_req.
REQ-007 vid_dout  output  DW  registered video read data.
REQ-008 vid_valid  output  1  one-cycle strobe, vid_dout valid.
REQ-009 cpu_req  input  1  CPU access request, level.
REQ-010 cpu_we  input  1  1 = write, 0 = read.
REQ-011 cpu_addr  input  AW  CPU word address.
REQ-012 cpu_wdata  input  DW  CPU write data.
REQ-013 cpu_be  input  2  byte enables, [1] = bits 15:8, [0] = bits 7:0.
REQ-014 cpu_rdata  output  DW  registered CPU read data.
REQ-015 cpu_ack  output  1  one-cycle completion strobe.
REQ-016 cpu_busy  output  1  CPU command latched and not yet acked.
REQ-017 ram_addr, ram_we, ram_be, ram_wdata  outputs  AW/1/2/DW  registered single-port RAM command.
REQ-018 ram_rdata  input  DW  RAM read data, valid exactly 1 cycle after the command cycle.

Function
REQ-019 One RAM access per cycle; each cycle's slot goes to exactly one of: video, CPU, idle.
REQ-020 Video has strict priority: vid_req at cycle T drives a read command on the ram_* outputs in cycle T+1, regardless of CPU state.
REQ-021 Video latency is fixed: vid_dout is loaded with ram_rdata and vid_valid pulses in cycle T+3; latency never varies with CPU traffic.
REQ-022 vid_req on consecutive cycles is legal; each request produces its own vid_valid, in order, 1 per cycle.
REQ-023 CPU command capture: while cpu_busy = 0 and cpu_req = 1, latch we/addr/wdata/be at the clock edge and set cpu_busy.
REQ-024 CPU inputs are ignored while cpu_busy = 1; after cpu_ack, a new request is accepted no earlier than the cycle after cpu_ack.
REQ-025 States: IDLE (no latched command), WAIT (latched, not issued), ISSUED (command on RAM, read data pending), DONE (ack cycle).
REQ-026 WAIT -> ISSUED in the first slot with no video command; the slot is unavailable if vid_req was asserted in the previous cycle.
REQ-027 Write: issue with ram_we = 1 and ram_be = latched be; cpu_ack in the following cycle; cpu_rdata unchanged.
REQ-028 Read: issue with ram_we = 0; cpu_rdata loaded from ram_rdata and cpu_ack pulses 2 cycles after issue.
REQ-029 cpu_ack drops cpu_busy in the same cycle; state returns to IDLE.
REQ-030 Simultaneous vid_req and pending CPU command: video wins; the CPU stays in WAIT with no loss or corruption of latched data.
REQ-031 Continuous vid_req starves the CPU indefinitely; there is no timeout and no ack.
REQ-032 Idle slot: ram_we = 0, ram_be = 0; ram_addr holds its previous value.
REQ-033 A video read during the cycle after a CPU write to the same address returns the new data, per single-port RAM semantics.

Reset
REQ-034 reset_n low asynchronously clears vid_valid, cpu_ack, cpu_busy, ram_we, ram_be, vid_dout, cpu_rdata, ram_addr, ram_wdata and the pipeline tags, and forces IDLE.
REQ-035 Reset during an outstanding access discards it: no vid_valid or cpu_ack is produced for any request issued before reset.
REQ-036 The first request is accepted at the first rising edge with reset_n high.

Verification
REQ-037 Video-only: vid_req at T with addr 0x0123 and RAM[0x0123] = 0xA55A -> ram_addr = 0x0123 at T+1, vid_dout = 0xA55A with vid_valid at T+3.
REQ-038 CPU write, no video: cpu_req, we = 1, addr 0x0040, wdata 0x1234, be = 2'b01 -> single RAM write with be 01; cpu_ack 2 cycles after the request edge; RAM[0x0040][7:0] = 0x34, upper byte unchanged.
REQ-039 Collision: cpu read pending and vid_req every cycle for 5 cycles -> 5 vid_valid pulses at fixed latency; the CPU issues in the first free slot; cpu_ack returns correct data.
REQ-040 Video burst every 4 cycles (hires cadence) with back-to-back CPU reads -> every vid_valid is exactly 3 cycles after its vid_req; all CPU reads complete in order.
REQ-041 reset_n pulsed low while a CPU read is in ISSUED -> no cpu_ack, cpu_busy = 0; a subsequent request completes normally.
REQ-042 cpu_req held high across cpu_ack -> exactly one ack per accepted command; a second command is accepted the cycle after the ack.

Source files
------------

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Shares one single-port video RAM between a fixed-latency video
//            fetch port and a CPU port. Video reads own any slot they ask for
//            and return data exactly three cycles after vid_req. The CPU gets
//            one latched command at a time, issued in the first slot video
//            leaves free.
// Ports    : clk, reset_n          - clock, async active-low reset
//            vid_req/vid_addr      - one-cycle video read strobe and address
//            vid_dout/vid_valid    - registered video data + strobe
//            cpu_req/we/addr/wdata/be - CPU command (level request)
//            cpu_rdata/ack/busy    - CPU read data, completion, busy flag
//            ram_addr/we/be/wdata  - registered RAM command
//            ram_rdata             - RAM data, one cycle after its command
// Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
    parameter int AW = 14,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_dout,
    output logic          vid_valid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic [1:0]    cpu_be,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_busy,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [1:0]    ram_be,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ISSUED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          phase_q, phase_d;       // read: 0 = command cycle, 1 = data cycle
    logic          lat_we_q, lat_we_d;
    logic [AW-1:0] lat_addr_q, lat_addr_d;
    logic [DW-1:0] lat_wdata_q, lat_wdata_d;
    logic [1:0]    lat_be_q, lat_be_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          cpu_busy_q, cpu_busy_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          ram_we_q, ram_we_d;
    logic [1:0]    ram_be_q, ram_be_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    // Video pipeline tags: command on RAM, data on ram_rdata.
    logic          vid_cmd_q, vid_cmd_d;
    logic          vid_rd_q, vid_rd_d;
    logic          vid_valid_q, vid_valid_d;
    logic [DW-1:0] vid_dout_q, vid_dout_d;

    // CPU command FSM. DONE always falls back to IDLE, so a request held
    // across the ack is only sampled again in the cycle after the ack.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        lat_we_d    = lat_we_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        lat_be_d    = lat_be_q;
        cpu_rdata_d = cpu_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    lat_we_d    = cpu_we;
                    lat_addr_d  = cpu_addr;
                    lat_wdata_d = cpu_wdata;
                    lat_be_d    = cpu_be;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                // vid_req this cycle claims the next slot.
                if (!vid_req) begin
                    state_d = S_ISSUED;
                    phase_d = 1'b0;
                end
            end
            S_ISSUED: begin
                if (lat_we_q || phase_q) begin
                    state_d = S_DONE;
                    if (!lat_we_q) begin
                        cpu_rdata_d = ram_rdata;
                    end
                end else begin
                    phase_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        cpu_ack_d  = (state_d == S_DONE);
        cpu_busy_d = (state_d == S_WAIT) || (state_d == S_ISSUED);
    end

    // Slot owner for the next cycle: video, else a waiting CPU command,
    // else idle (no enables, address held).
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_be_d    = 2'b00;
        ram_wdata_d = ram_wdata_q;
        if (vid_req) begin
            ram_addr_d = vid_addr;
            ram_be_d   = 2'b11;
        end else if (state_q == S_WAIT) begin
            ram_addr_d = lat_addr_q;
            ram_we_d   = lat_we_q;
            if (lat_we_q) begin
                ram_be_d    = lat_be_q;
                ram_wdata_d = lat_wdata_q;
            end else begin
                ram_be_d    = 2'b11;
            end
        end
    end

    always_comb begin
        vid_cmd_d   = vid_req;
        vid_rd_d    = vid_cmd_q;
        vid_valid_d = vid_rd_q;
        vid_dout_d  = vid_rd_q ? ram_rdata : vid_dout_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            phase_q     <= 1'b0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_be_q    <= 2'b00;
            cpu_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_busy_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_be_q    <= 2'b00;
            ram_wdata_q <= '0;
            vid_cmd_q   <= 1'b0;
            vid_rd_q    <= 1'b0;
            vid_valid_q <= 1'b0;
            vid_dout_q  <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            lat_we_q    <= lat_we_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            lat_be_q    <= lat_be_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_busy_q  <= cpu_busy_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_be_q    <= ram_be_d;
            ram_wdata_q <= ram_wdata_d;
            vid_cmd_q   <= vid_cmd_d;
            vid_rd_q    <= vid_rd_d;
            vid_valid_q <= vid_valid_d;
            vid_dout_q  <= vid_dout_d;
        end
    end

    assign vid_dout  = vid_dout_q;
    assign vid_valid = vid_valid_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_busy  = cpu_busy_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_be    = ram_be_q;
    assign ram_wdata = ram_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Purpose  : Scoreboard bench for vram_arbiter with a behavioural byte-write
//            single-port RAM. Directed stimulus pushes expected data and the
//            expected output cycle; a negedge monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

    localparam int AW = 14;
    localparam int DW = 16;

    logic          clk;
    logic          reset_n;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_dout;
    logic          vid_valid;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [1:0]    cpu_be;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          cpu_busy;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [1:0]    ram_be;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    vram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_dout(vid_dout), .vid_valid(vid_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_busy(cpu_busy),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_be(ram_be),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM, preloaded with hand-chosen words on the first edge.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    bit mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            mem[14'h0123] <= 16'hA55A;
            mem[14'h0040] <= 16'hBEEF;
            mem[14'h0050] <= 16'h0000;
            mem[14'h0061] <= 16'h1111;
            mem[14'h0070] <= 16'h7070;
            mem[14'h0071] <= 16'h7171;
            mem[14'h0072] <= 16'h7272;
            mem_init      <= 1'b1;
        end else begin
            if (ram_we && ram_be[0]) mem[ram_addr][7:0]  <= ram_wdata[7:0];
            if (ram_we && ram_be[1]) mem[ram_addr][15:8] <= ram_wdata[15:8];
            ram_rdata <= mem[ram_addr];
        end
    end

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
        logic          rd;
    } exp_t;

    exp_t vq[$];
    exp_t cq[$];
    int   tests = 0;
    int   fails = 0;
    int   wr_cnt = 0;
    logic [1:0] last_be = 2'b00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (ram_we) begin
                    wr_cnt++;
                    last_be = ram_be;
                end
                if (vid_valid) begin
                    if (vq.size() == 0) begin
                        chk("vid_unexpected_valid", {31'd0, vid_valid}, 32'd0);
                    end else begin
                        e = vq.pop_front();
                        chk("vid_cycle", cyc, e.cyc);
                        chk("vid_data", {16'd0, vid_dout}, {16'd0, e.data});
                    end
                end
                if (cpu_ack) begin
                    if (cq.size() == 0) begin
                        chk("cpu_unexpected_ack", {31'd0, cpu_ack}, 32'd0);
                    end else begin
                        e = cq.pop_front();
                        chk("cpu_ack_cycle", cyc, e.cyc);
                        if (e.rd) chk("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, e.data});
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        vid_req = 1'b0;
        cpu_req = 1'b0;
    endtask

    task automatic vid(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        vid_req  = 1'b1;
        vid_addr = a;
        e.data = d; e.cyc = cyc + 3; e.rd = 1'b1;
        vq.push_back(e);
    endtask

    // lat = cycles from request cycle to ack; 0 = no ack expected.
    task automatic cpu(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [1:0] be, input logic [DW-1:0] rd_exp, input int lat);
        exp_t e;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        cpu_be    = be;
        if (lat != 0) begin
            e.data = rd_exp; e.cyc = cyc + lat; e.rd = !we;
            cq.push_back(e);
        end
    endtask

    logic [AW-1:0] col_a [5] = '{14'h0123, 14'h0040, 14'h0050, 14'h0070, 14'h0071};
    logic [DW-1:0] col_d [5] = '{16'hA55A, 16'hBE34, 16'hCAFE, 16'h7070, 16'h7171};

    initial begin
        reset_n = 1'b0; vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = 2'b00;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        chk("rst_vid_valid", {31'd0, vid_valid}, 32'd0);
        chk("rst_cpu_ack",   {31'd0, cpu_ack},   32'd0);
        chk("rst_cpu_busy",  {31'd0, cpu_busy},  32'd0);
        chk("rst_ram_we",    {31'd0, ram_we},    32'd0);
        chk("rst_ram_be",    {30'd0, ram_be},    32'd0);
        chk("rst_ram_addr",  {18'd0, ram_addr},  32'd0);
        chk("rst_ram_wdata", {16'd0, ram_wdata}, 32'd0);
        chk("rst_vid_dout",  {16'd0, vid_dout},  32'd0);
        chk("rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);

        // Video-only read: command next cycle, data three cycles later
        vid(14'h0123, 16'hA55A);
        step();
        chk("vid_cmd_addr", {18'd0, ram_addr}, 32'h0123);
        chk("vid_cmd_we",   {31'd0, ram_we},   32'd0);
        step();
        chk("idle_be",        {30'd0, ram_be},   32'd0);
        chk("idle_we",        {31'd0, ram_we},   32'd0);
        chk("idle_addr_hold", {18'd0, ram_addr}, 32'h0123);
        repeat (3) step();

        // CPU byte write, no video
        cpu(1'b1, 14'h0040, 16'h1234, 2'b01, 16'h0000, 3);
        repeat (6) step();
        chk("wr_count",      wr_cnt, 32'd1);
        chk("wr_be",         {30'd0, last_be}, 32'h1);
        chk("mem_0040",      {16'd0, mem[14'h0040]}, 32'hBE34);
        chk("wr_rdata_hold", {16'd0, cpu_rdata}, 32'd0);

        // Write then video read of the same word in the next slot
        cpu(1'b1, 14'h0050, 16'hCAFE, 2'b11, 16'h0000, 3);
        step();
        step();
        vid(14'h0050, 16'hCAFE);
        repeat (6) step();
        chk("wr_count2", wr_cnt, 32'd2);

        // Collision: pending CPU read against five back-to-back video reads
        cpu(1'b0, 14'h0061, 16'h0000, 2'b00, 16'h1111, 9);
        step();
        for (int k = 0; k < 5; k++) begin
            vid(col_a[k], col_d[k]);
            cpu_addr  = 14'h3FFF;
            cpu_wdata = 16'hDEAD;
            step();
            chk("collision_busy", {31'd0, cpu_busy}, 32'd1);
        end
        repeat (8) step();
        chk("collision_busy_end", {31'd0, cpu_busy}, 32'd0);

        // Video every 4 cycles with back-to-back CPU reads
        for (int b = 0; b < 16; b++) begin
            if (b == 1)  vid(14'h0123, 16'hA55A);
            if (b == 5)  vid(14'h0061, 16'h1111);
            if (b == 9)  vid(14'h0050, 16'hCAFE);
            if (b == 13) vid(14'h0040, 16'hBE34);
            if (b == 0)  cpu(1'b0, 14'h0070, 16'h0000, 2'b00, 16'h7070, 5);
            if (b == 6)  cpu(1'b0, 14'h0071, 16'h0000, 2'b00, 16'h7171, 4);
            if (b == 11) cpu(1'b0, 14'h0072, 16'h0000, 2'b00, 16'h7272, 4);
            step();
        end
        repeat (6) step();

        // Reset while a CPU read is in flight: nothing may come back
        cpu(1'b0, 14'h0070, 16'h0000, 2'b00, 16'h0000, 0);
        step();
        step();
        vid_req  = 1'b1;
        vid_addr = 14'h0123;
        step();
        chk("pre_reset_busy", {31'd0, cpu_busy}, 32'd1);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        chk("post_reset_busy", {31'd0, cpu_busy}, 32'd0);
        chk("post_reset_ack",  {31'd0, cpu_ack},  32'd0);
        repeat (6) step();
        cpu(1'b0, 14'h0071, 16'h0000, 2'b00, 16'h7171, 4);
        repeat (6) step();

        // cpu_req held across the ack: one ack, next command the cycle after
        cpu(1'b0, 14'h0123, 16'h0000, 2'b00, 16'hA55A, 4);
        for (int i = 0; i < 4; i++) begin
            step();
            cpu_req = 1'b1;
        end
        step();
        cpu(1'b0, 14'h0040, 16'h0000, 2'b00, 16'hBE34, 4);
        repeat (8) step();

        chk("vid_queue_empty", vq.size(), 32'd0);
        chk("cpu_queue_empty", cq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
